// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial receiver with valid/ready output,
// framing-error and overrun pulses.
module uart_receiver #(
  parameter int CLKS_PER_BIT = 104,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL =
    CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF =
    CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK
  } state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;
  logic                   rxs_q;
  logic [CW-1:0]          cnt, cnt_n;
  logic [2:0]             bidx, bidx_n;
  logic [7:0]             shreg, shreg_n;
  logic                   done;
  logic                   ferr;
  logic                   load;

  assign rxs  = sync_q[SYNC_STAGES-1];
  assign busy = (state != IDLE);
  assign load = done & (~rx_valid | rx_ready);

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    bidx_n  = bidx;
    shreg_n = shreg;
    done    = 1'b0;
    ferr    = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        // edge-detect cycle is the first low cycle of the start bit
        if (rxs_q && !rxs) begin
          state_n = START;
          cnt_n   = CW'(1);
        end
      end
      START: begin
        if (cnt == HALF) begin
          cnt_n   = '0;
          bidx_n  = '0;
          state_n = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == FULL) begin
          cnt_n   = '0;
          shreg_n = {rxs, shreg[7:1]};
          bidx_n  = bidx + 3'd1;
          if (bidx == 3'd7) begin
            state_n = STOP;
          end
        end
      end
      STOP: begin
        if (cnt == FULL) begin
          cnt_n = '0;
          if (rxs) begin
            done    = 1'b1;
            state_n = IDLE;
          end else begin
            ferr    = 1'b1;
            state_n = BRK;
          end
        end
      end
      BRK: begin
        cnt_n = '0;
        if (rxs) begin
          state_n = IDLE;
        end
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      sync_q <= '1;
      rxs_q  <= 1'b1;
      cnt    <= '0;
      bidx   <= '0;
      shreg  <= '0;
    end else begin
      state  <= state_n;
      sync_q <= {sync_q[SYNC_STAGES-2:0], uart_rx};
      rxs_q  <= rxs;
      cnt    <= cnt_n;
      bidx   <= bidx_n;
      shreg  <= shreg_n;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr;
      overrun   <= done & ~load;
      if (load) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed frames with a queue scoreboard
// checked by a handshake monitor.
module tb_uart_receiver;

  localparam int CPB  = 16;
  localparam int SYNC = 2;
  localparam int LAT  = SYNC + CPB / 2 + 9 * CPB;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       uart_rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int accepts = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;

  logic [7:0] exp_q[$];
  logic       prev_v = 1'b0;
  logic       prev_hs = 1'b0;
  logic [7:0] prev_d = '0;

  uart_receiver #(
    .CLKS_PER_BIT(CPB),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .uart_rx  (uart_rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic hold(input logic v, input int n);
    uart_rx = v;
    repeat (n) tick();
  endtask

  task automatic send_frame(input logic [7:0] b,
                            input logic stopv,
                            input int stopn);
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(b[i], CPB);
    hold(stopv, stopn);
  endtask

  task automatic ready_pulse();
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask

  always @(negedge clock) begin
    if (reset) begin
      prev_v  = 1'b0;
      prev_hs = 1'b0;
    end else begin
      if (prev_v && !prev_hs && rx_valid)
        chk("data_stable", rx_data, prev_d);
      if (rx_valid && rx_ready) begin
        accepts++;
        if (exp_q.size() == 0) begin
          chk("unexpected_byte", rx_data, 32'hffff);
        end else begin
          chk("rx_data", rx_data, exp_q.pop_front());
        end
      end
      if (frame_err) ferr_cnt++;
      if (overrun) ovr_cnt++;
      if (frame_err || overrun)
        chk("err_exclusive", frame_err & overrun, 0);
      prev_v  = rx_valid;
      prev_hs = rx_valid & rx_ready;
      prev_d  = rx_data;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int seen;
    int acc0;
    int cnt0;

    // reset state
    repeat (3) tick();
    @(negedge clock);
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_busy", busy, 0);
    tick();
    reset = 1'b0;
    repeat (4) tick();

    // 0x55 with latency check, held until accepted
    exp_q.push_back(8'h55);
    e0 = cyc;
    seen = 0;
    fork
      send_frame(8'h55, 1'b1, CPB);
      begin
        for (int k = 0; k < 400; k++) begin
          @(negedge clock);
          if (rx_valid) begin
            seen = 1;
            break;
          end
        end
        chk("valid_seen", seen, 1);
        chk("latency", cyc - e0, LAT);
      end
    join
    repeat (20) tick();
    @(negedge clock);
    chk("held_valid", rx_valid, 1);
    chk("held_data", rx_data, 8'h55);
    tick();
    ready_pulse();
    @(negedge clock);
    chk("cleared_valid", rx_valid, 0);

    // back-to-back 0x4B, 0x00 with ready tied high
    tick();
    rx_ready = 1'b1;
    acc0 = accepts;
    cnt0 = ferr_cnt + ovr_cnt;
    exp_q.push_back(8'h4B);
    exp_q.push_back(8'h00);
    send_frame(8'h4B, 1'b1, CPB / 2 + 2);
    send_frame(8'h00, 1'b1, CPB);
    repeat (4) tick();
    chk("b2b_accepts", accepts - acc0, 2);
    chk("b2b_no_err", ferr_cnt + ovr_cnt, cnt0);
    rx_ready = 1'b0;

    // false start glitch
    hold(1'b0, 3);
    uart_rx = 1'b1;
    @(negedge clock);
    chk("glitch_busy_hi", busy, 1);
    repeat (20) tick();
    @(negedge clock);
    chk("glitch_busy_lo", busy, 0);
    chk("glitch_valid", rx_valid, 0);

    // framing error with long break, then 0x3C
    tick();
    cnt0 = ferr_cnt;
    send_frame(8'hA5, 1'b0, 40 * CPB);
    hold(1'b1, 2 * CPB);
    @(negedge clock);
    chk("break_ferr_once", ferr_cnt - cnt0, 1);
    chk("break_valid", rx_valid, 0);
    chk("break_busy", busy, 0);
    tick();
    rx_ready = 1'b1;
    acc0 = accepts;
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, CPB);
    repeat (4) tick();
    chk("after_break_acc", accepts - acc0, 1);
    rx_ready = 1'b0;

    // overrun: 0x11 retained, 0x22 dropped
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, CPB);
    cnt0 = ovr_cnt;
    send_frame(8'h22, 1'b1, CPB);
    @(negedge clock);
    chk("ovr_once", ovr_cnt - cnt0, 1);
    chk("ovr_kept", rx_data, 8'h11);
    chk("ovr_valid", rx_valid, 1);
    tick();

    // 0x33 completes in the same cycle as the accept
    exp_q.push_back(8'h33);
    cnt0 = ovr_cnt;
    fork
      send_frame(8'h33, 1'b1, CPB);
      begin
        repeat (LAT - 1) tick();
        ready_pulse();
      end
    join
    @(negedge clock);
    chk("same_cyc_no_ovr", ovr_cnt, cnt0);
    chk("same_cyc_data", rx_data, 8'h33);
    chk("same_cyc_valid", rx_valid, 1);
    tick();
    ready_pulse();

    // reset mid-frame with a byte pending
    send_frame(8'h77, 1'b1, CPB);
    @(negedge clock);
    chk("pending_valid", rx_valid, 1);
    tick();
    acc0 = accepts;
    fork
      send_frame(8'hF0, 1'b1, CPB);
      begin
        repeat (86) tick();
        @(negedge clock);
        chk("mid_busy", busy, 1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clock);
        chk("mid_rst_valid", rx_valid, 0);
        chk("mid_rst_data", rx_data, 0);
        chk("mid_rst_busy", busy, 0);
      end
    join
    repeat (2 * CPB) tick();
    @(negedge clock);
    chk("no_partial", rx_valid, 0);
    chk("no_partial_acc", accepts, acc0);
    tick();
    rx_ready = 1'b1;
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1, CPB);
    repeat (4) tick();
    chk("c3_acc", accepts - acc0, 1);
    rx_ready = 1'b0;

    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
